mem_stage_mc: RTL and testbench

- Parametrised memory-stage data memory for the pipelined MIPS core. Replaces the fixed single-cycle DM path.
- Word array of configurable depth with byte, half and word loads and stores, and sign or zero extension on loads.
- Access latency is configurable. While an access is in flight, a stall output freezes the upstream pipeline.
- Misaligned accesses are detected and reported instead of performed. A store-trace port reports every committed write together with its PC.

---
 rtl/mem_stage_mc_if.sv | 30 +++
 rtl/mem_stage_mc.sv | 133 +++++++++++++
 tb/tb_mem_stage_mc.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_mc_if.sv
// Request/response bundle between the pipeline MEM stage and the data memory.
// Master drives req_*, slave returns stall, load data, exceptions and store trace.
interface mem_stage_mc_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc,
    input  stall, rdata_valid, rdata, exc_valid, exc_addr, wr_valid, wr_pc, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc,
    output stall, rdata_valid, rdata, exc_valid, exc_addr, wr_valid, wr_pc, wr_addr, wr_data
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Data memory for the MEM stage: byte/half/word loads and stores, misalignment traps, store trace.
// Latency: LATENCY cycles of occupancy to commit, responses registered one cycle later.
// Backpressure: combinational stall holds the upstream request until its commit cycle.
module mem_stage_mc #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  mem_stage_mc_if.slave bus
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   cur_word, merged, ld_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          illegal, commit, reject, stall_c;
  logic          unused_addr_hi;

  // Addresses wrap modulo the array size; upper bits are deliberately ignored.
  assign idx            = bus.req_addr[AW+1:2];
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];
  assign cur_word       = mem[idx];

  always_comb begin
    illegal = 1'b0;
    case (bus.req_width)
      2'b00:   illegal = (bus.req_addr[1:0] != 2'b00);
      2'b01:   illegal = bus.req_addr[0];
      2'b10:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    merged  = cur_word;
    ld_byte = cur_word[{bus.req_addr[1:0], 3'b000} +: 8];
    ld_half = cur_word[{bus.req_addr[1], 4'b0000} +: 16];
    ld_val  = cur_word;
    case (bus.req_width)
      2'b10: begin
        merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
        ld_val = bus.req_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      end
      2'b01: begin
        merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
        ld_val = bus.req_sign ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      end
      default: merged = bus.req_wdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    reject    = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal) begin
            reject = 1'b1;
          end else if (LATENCY == 1) begin
            commit = 1'b1;
          end else begin
            stall_c   = 1'b1;
            cnt_nxt   = 4'd1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // A dropped request is abandoned silently rather than committed.
        if (!bus.req_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == LAST) begin
          commit    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.stall = reset & stall_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      bus.rdata_valid <= 1'b0;
      bus.rdata       <= 32'h0;
      bus.exc_valid   <= 1'b0;
      bus.exc_addr    <= 32'h0;
      bus.wr_valid    <= 1'b0;
      bus.wr_pc       <= 32'h0;
      bus.wr_addr     <= 32'h0;
      bus.wr_data     <= 32'h0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.rdata_valid <= commit & ~bus.req_we;
      bus.wr_valid    <= commit & bus.req_we;
      bus.exc_valid   <= reject;
      if (reject) bus.exc_addr <= bus.req_addr;
      if (commit && !bus.req_we) bus.rdata <= ld_val;
      if (commit && bus.req_we) begin
        mem[idx]    <= merged;
        bus.wr_pc   <= bus.req_pc;
        bus.wr_addr <= 32'({idx, 2'b00});
        bus.wr_data <= merged;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc at LATENCY 1, 3 and 4 (DEPTH 4096) with immediate-assertion checks.
module tb_mem_stage_mc;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic        o_rv, o_ev, o_wv;
  logic [31:0] o_rd, o_ea, o_wpc, o_wa, o_wd;

  mem_stage_mc_if b1 ();
  mem_stage_mc_if b3 ();
  mem_stage_mc_if b4 ();

  mem_stage_mc #(.DEPTH(4096), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  mem_stage_mc #(.DEPTH(4096), .LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  mem_stage_mc #(.DEPTH(4096), .LATENCY(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic get_stall(input int d);
    case (d)
      1:       return b1.stall;
      3:       return b3.stall;
      default: return b4.stall;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic we, input logic [1:0] w,
                       input logic s, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc);
    b1.req_valid = v && (d == 1);
    b3.req_valid = v && (d == 3);
    b4.req_valid = v && (d == 4);
    b1.req_we = we;   b3.req_we = we;   b4.req_we = we;
    b1.req_width = w; b3.req_width = w; b4.req_width = w;
    b1.req_sign = s;  b3.req_sign = s;  b4.req_sign = s;
    b1.req_addr = a;  b3.req_addr = a;  b4.req_addr = a;
    b1.req_wdata = wd; b3.req_wdata = wd; b4.req_wdata = wd;
    b1.req_pc = pc;   b3.req_pc = pc;   b4.req_pc = pc;
  endtask

  task automatic snap(input int d);
    case (d)
      1: begin o_rv = b1.rdata_valid; o_rd = b1.rdata; o_ev = b1.exc_valid; o_ea = b1.exc_addr;
               o_wv = b1.wr_valid; o_wpc = b1.wr_pc; o_wa = b1.wr_addr; o_wd = b1.wr_data; end
      3: begin o_rv = b3.rdata_valid; o_rd = b3.rdata; o_ev = b3.exc_valid; o_ea = b3.exc_addr;
               o_wv = b3.wr_valid; o_wpc = b3.wr_pc; o_wa = b3.wr_addr; o_wd = b3.wr_data; end
      default: begin o_rv = b4.rdata_valid; o_rd = b4.rdata; o_ev = b4.exc_valid; o_ea = b4.exc_addr;
               o_wv = b4.wr_valid; o_wpc = b4.wr_pc; o_wa = b4.wr_addr; o_wd = b4.wr_data; end
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after the commit edge with outputs captured.
  task automatic req(input int d, input logic we, input logic [1:0] w, input logic s,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                     input int exp_stall);
    int n = 0;
    drive(d, 1'b1, we, w, s, a, wd, pc);
    #1;
    while (get_stall(d) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    @(negedge clk);
    snap(d);
    drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    snap(1);
    chk("init_rv", 32'(o_rv), 32'h0);
    chk("init_wv", 32'(o_wv), 32'h0);
    chk("init_rdata", o_rd, 32'h0);
    reset = 1'b1;

    req(1, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h10, 0);
    chk("pre_wv", 32'(o_wv), 32'h1);
    chk("pre_wd", o_wd, 32'h1111_1111);
    req(1, 1'b1, 2'b00, 1'b0, 32'h0000_0004, 32'h2222_2222, 32'h14, 0);
    req(1, 1'b1, 2'b00, 1'b0, 32'h0000_3FFC, 32'h3333_3333, 32'h18, 0);
    chk("pre_wa", o_wa, 32'h0000_3FFC);

    drive(3, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(b3.stall), 32'h0);
    @(negedge clk);
    snap(1);
    chk("rst_wv", 32'(o_wv), 32'h0);
    chk("rst_wd", o_wd, 32'h0);
    chk("rst_wpc", o_wpc, 32'h0);
    chk("rst_rv3", 32'(b3.rdata_valid), 32'h0);
    reset = 1'b1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

    req(1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h20, 0);
    chk("clr0_rv", 32'(o_rv), 32'h1);
    chk("clr0", o_rd, 32'h0);
    req(1, 1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 32'h24, 0);
    chk("clr4", o_rd, 32'h0);
    req(1, 1'b0, 2'b00, 1'b0, 32'h0000_3FFC, 32'h0, 32'h28, 0);
    chk("clr3ffc", o_rd, 32'h0);

    req(1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678, 32'h100, 0);
    chk("sw_wd", o_wd, 32'h1234_5678);
    req(1, 1'b1, 2'b10, 1'b0, 32'h11, 32'h0000_00AB, 32'h104, 0);
    chk("sb_wd", o_wd, 32'h1234_AB78);
    chk("sb_wa", o_wa, 32'h10);
    chk("sb_wpc", o_wpc, 32'h104);
    chk("sb_rv", 32'(o_rv), 32'h0);
    req(1, 1'b0, 2'b10, 1'b1, 32'h11, 32'h0, 32'h108, 0);
    chk("lb", o_rd, 32'hFFFF_FFAB);
    req(1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h10C, 0);
    chk("lbu", o_rd, 32'h0000_00AB);
    req(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h110, 0);
    chk("lh_hi", o_rd, 32'h0000_1234);
    req(1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h114, 0);
    chk("lh_lo", o_rd, 32'hFFFF_AB78);
    req(1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h118, 0);
    chk("lbu3", o_rd, 32'h0000_0012);

    req(1, 1'b1, 2'b00, 1'b0, 32'h4000, 32'hDEAD_BEEF, 32'h200, 0);
    chk("wrap_wa", o_wa, 32'h0);
    req(1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h204, 0);
    chk("wrap_rd", o_rd, 32'hDEAD_BEEF);

    req(1, 1'b1, 2'b00, 1'b0, 32'h4, 32'hCAFE_F00D, 32'h300, 0);
    req(1, 1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 32'h304, 0);
    chk("lw2_ev", 32'(o_ev), 32'h1);
    chk("lw2_ea", o_ea, 32'h2);
    chk("lw2_rv", 32'(o_rv), 32'h0);
    req(1, 1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_1111, 32'h308, 0);
    chk("sh5_ev", 32'(o_ev), 32'h1);
    chk("sh5_ea", o_ea, 32'h5);
    chk("sh5_wv", 32'(o_wv), 32'h0);
    req(1, 1'b1, 2'b11, 1'b0, 32'h4, 32'h5555_5555, 32'h30C, 0);
    chk("w11_ev", 32'(o_ev), 32'h1);
    req(1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h310, 0);
    chk("mis_rb", o_rd, 32'hCAFE_F00D);
    chk("mis_rb_ev", 32'(o_ev), 32'h0);

    req(3, 1'b1, 2'b00, 1'b0, 32'h40, 32'h55AA_33CC, 32'h400, 2);
    chk("l3_wv", 32'(o_wv), 32'h1);
    chk("l3_wpc", o_wpc, 32'h400);
    chk("l3_wa", o_wa, 32'h40);
    chk("l3_wd", o_wd, 32'h55AA_33CC);
    req(3, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h404, 2);
    chk("l3_rv", 32'(o_rv), 32'h1);
    chk("l3_rd", o_rd, 32'h55AA_33CC);
    @(negedge clk);
    snap(3);
    chk("l3_rv_drop", 32'(o_rv), 32'h0);
    chk("l3_rd_hold", o_rd, 32'h55AA_33CC);
    req(3, 1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 32'h408, 0);
    chk("l3_exc", 32'(o_ev), 32'h1);

    drive(4, 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h7777_7777, 32'h500);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("l4_rst_stall", 32'(b4.stall), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(4, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("l4_post_stall", 32'(b4.stall), 32'h0);
    chk("l4_post_wv", 32'(b4.wr_valid), 32'h0);
    @(negedge clk);
    chk("l4_late_wv", 32'(b4.wr_valid), 32'h0);
    req(4, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h504, 3);
    chk("l4_rv", 32'(o_rv), 32'h1);
    chk("l4_rd", o_rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
